clock_counter: RTL and testbench

- Downstream consumer of the minute/second tick generator in the alarm clock datapath.
- Keeps the current time of day as four BCD digits (HH:MM, 24-hour) and advances it on each one_minute pulse.
- Accepts user loads of a new current time and a new alarm time, and raises a latched alarm when the current time reaches the alarm time.
- Drives reset_count back to the tick generator so the sub-minute count restarts on a time load.

---
 rtl/clock_counter_if.sv | 40 ++++
 rtl/clock_counter.sv | 86 ++++++++
 tb/tb_clock_counter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/clock_counter_if.sv
// Signal bundle between the alarm-clock user/tick side and the clock_counter core.
interface clock_counter_if;
    logic       one_minute;
    logic       load_new_c;
    logic       load_new_a;
    logic [3:0] new_time_h_ms;
    logic [3:0] new_time_h_ls;
    logic [3:0] new_time_m_ms;
    logic [3:0] new_time_m_ls;
    logic       alarm_button;
    logic       stop_alarm;
    logic [3:0] current_time_h_ms;
    logic [3:0] current_time_h_ls;
    logic [3:0] current_time_m_ms;
    logic [3:0] current_time_m_ls;
    logic [3:0] alarm_time_h_ms;
    logic [3:0] alarm_time_h_ls;
    logic [3:0] alarm_time_m_ms;
    logic [3:0] alarm_time_m_ls;
    logic       alarm;
    logic       reset_count;

    modport master (
        output one_minute, load_new_c, load_new_a,
               new_time_h_ms, new_time_h_ls, new_time_m_ms, new_time_m_ls,
               alarm_button, stop_alarm,
        input  current_time_h_ms, current_time_h_ls, current_time_m_ms, current_time_m_ls,
               alarm_time_h_ms, alarm_time_h_ls, alarm_time_m_ms, alarm_time_m_ls,
               alarm, reset_count
    );

    modport slave (
        input  one_minute, load_new_c, load_new_a,
               new_time_h_ms, new_time_h_ls, new_time_m_ms, new_time_m_ls,
               alarm_button, stop_alarm,
        output current_time_h_ms, current_time_h_ls, current_time_m_ms, current_time_m_ls,
               alarm_time_h_ms, alarm_time_h_ls, alarm_time_m_ms, alarm_time_m_ls,
               alarm, reset_count
    );
endinterface

// File: rtl/clock_counter.sv
// 24-hour BCD time-of-day counter with loadable current/alarm time and a latched alarm.
module clock_counter #(
    parameter int ALARM_ON_LOAD = 0
) (
    input  logic           clk,
    input  logic           reset,
    clock_counter_if.slave bus
);
    logic [15:0] r_cur;
    logic [15:0] r_alm;
    logic        r_upd;
    logic        r_alarm;

    logic [15:0] w_new;
    logic        w_valid;
    logic        w_ld_c;
    logic        w_ld_a;
    logic        w_inc;
    logic        w_match;

    function automatic logic f_valid(input logic [15:0] t);
        return (t[15:12] <= 4'd2) && (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) &&
               (t[3:0] <= 4'd9) && ((t[15:12] != 4'd2) || (t[11:8] <= 4'd3));
    endfunction

    function automatic logic [15:0] f_inc(input logic [15:0] t);
        logic [15:0] n;
        n = t;
        if (t[3:0] != 4'd9) begin
            n[3:0] = t[3:0] + 4'd1;
        end else begin
            n[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                n[7:4] = t[7:4] + 4'd1;
            end else begin
                n[7:4] = 4'd0;
                if (t[15:8] == 8'h23) begin
                    n[15:8] = 8'h00;
                end else if (t[11:8] == 4'd9) begin
                    n[11:8]  = 4'd0;
                    n[15:12] = t[15:12] + 4'd1;
                end else begin
                    n[11:8] = t[11:8] + 4'd1;
                end
            end
        end
        return n;
    endfunction

    assign w_new   = {bus.new_time_h_ms, bus.new_time_h_ls, bus.new_time_m_ms, bus.new_time_m_ls};
    assign w_valid = f_valid(w_new);
    assign w_ld_c  = bus.load_new_c && w_valid;
    assign w_ld_a  = bus.load_new_a && w_valid;
    // an accepted load swallows a coincident tick; a rejected one lets it through
    assign w_inc   = !w_ld_c && bus.one_minute;
    // r_upd marks that r_cur was rewritten on the previous edge
    assign w_match = r_upd && (r_cur == r_alm);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur   <= 16'h0000;
            r_alm   <= 16'h0000;
            r_upd   <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            if (w_ld_c)
                r_cur <= w_new;
            else if (w_inc)
                r_cur <= f_inc(r_cur);
            r_upd <= w_inc || (w_ld_c && (ALARM_ON_LOAD != 0));
            if (w_ld_a)
                r_alm <= w_new;
            if (!bus.alarm_button || bus.stop_alarm)
                r_alarm <= 1'b0;
            else if (w_match)
                r_alarm <= 1'b1;
        end
    end

    assign {bus.current_time_h_ms, bus.current_time_h_ls,
            bus.current_time_m_ms, bus.current_time_m_ls} = r_cur;
    assign {bus.alarm_time_h_ms, bus.alarm_time_h_ls,
            bus.alarm_time_m_ms, bus.alarm_time_m_ls}     = r_alm;
    assign bus.alarm       = r_alarm;
    assign bus.reset_count = bus.load_new_c;
endmodule

// File: tb/tb_clock_counter.sv
// Runs ALARM_ON_LOAD=0 and =1 instances side by side against a minutes-of-day model.
module tb_clock_counter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        i_om = 0, i_lc = 0, i_la = 0, i_btn = 0, i_st = 0;
    logic [15:0] i_d = 16'h0000;

    clock_counter_if if0 ();
    clock_counter_if if1 ();

    assign {if0.one_minute, if0.load_new_c, if0.load_new_a, if0.alarm_button, if0.stop_alarm} =
           {i_om, i_lc, i_la, i_btn, i_st};
    assign {if1.one_minute, if1.load_new_c, if1.load_new_a, if1.alarm_button, if1.stop_alarm} =
           {i_om, i_lc, i_la, i_btn, i_st};
    assign {if0.new_time_h_ms, if0.new_time_h_ls, if0.new_time_m_ms, if0.new_time_m_ls} = i_d;
    assign {if1.new_time_h_ms, if1.new_time_h_ls, if1.new_time_m_ms, if1.new_time_m_ls} = i_d;

    clock_counter #(.ALARM_ON_LOAD(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    clock_counter #(.ALARM_ON_LOAD(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    logic [15:0] cur0, cur1, alm0, alm1;
    assign cur0 = {if0.current_time_h_ms, if0.current_time_h_ls, if0.current_time_m_ms, if0.current_time_m_ls};
    assign cur1 = {if1.current_time_h_ms, if1.current_time_h_ls, if1.current_time_m_ms, if1.current_time_m_ls};
    assign alm0 = {if0.alarm_time_h_ms, if0.alarm_time_h_ls, if0.alarm_time_m_ms, if0.alarm_time_m_ls};
    assign alm1 = {if1.alarm_time_h_ms, if1.alarm_time_h_ls, if1.alarm_time_m_ms, if1.alarm_time_m_ls};

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [15:0] tod2bcd(input int m);
        int h, mm;
        h  = (m / 60) % 24;
        mm = m % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    function automatic bit is_valid(input logic [15:0] d);
        int h;
        h = int'(d[15:12]) * 10 + int'(d[11:8]);
        return d[15:12] <= 2 && d[11:8] <= 9 && d[7:4] <= 5 && d[3:0] <= 9 && h <= 23;
    endfunction

    function automatic int bcd2min(input logic [15:0] d);
        return (int'(d[15:12]) * 10 + int'(d[11:8])) * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    // model state: minutes since midnight, per ALARM_ON_LOAD setting
    int m_cur[2], m_alm[2];
    bit m_upd[2], m_alarm[2];
    bit m_vld, m_match;
    int m_nm;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_cur[k] = 0; m_alm[k] = 0; m_upd[k] = 0; m_alarm[k] = 0;
            end
        end else begin
            m_vld = is_valid(i_d);
            m_nm  = bcd2min(i_d);
            for (int k = 0; k < 2; k++) begin
                m_match = m_upd[k] && (m_cur[k] == m_alm[k]);
                if (!i_btn || i_st) m_alarm[k] = 0;
                else if (m_match) m_alarm[k] = 1;
                if (i_lc && m_vld) begin
                    m_cur[k] = m_nm;
                    m_upd[k] = (k == 1);
                end else if (i_om) begin
                    m_cur[k] = (m_cur[k] + 1) % 1440;
                    m_upd[k] = 1;
                end else begin
                    m_upd[k] = 0;
                end
                if (i_la && m_vld) m_alm[k] = m_nm;
            end
        end
    end

    bit en = 0;
    always @(negedge clk) begin
        if (en) begin
            chk("cur0", 32'(cur0), 32'(tod2bcd(m_cur[0])));
            chk("alm0", 32'(alm0), 32'(tod2bcd(m_alm[0])));
            chk("alarm0", 32'(if0.alarm), 32'(m_alarm[0]));
            chk("rc0", 32'(if0.reset_count), 32'(i_lc));
            chk("cur1", 32'(cur1), 32'(tod2bcd(m_cur[1])));
            chk("alm1", 32'(alm1), 32'(tod2bcd(m_alm[1])));
            chk("alarm1", 32'(if1.alarm), 32'(m_alarm[1]));
            chk("rc1", 32'(if1.reset_count), 32'(i_lc));
        end
    end

    // apply inputs for one edge; returns 2 time units after that edge with pulses cleared
    task automatic cyc(input bit om, input bit lc, input bit la, input logic [15:0] d, input bit st);
        i_om = om; i_lc = lc; i_la = la; i_d = d; i_st = st;
        @(posedge clk); #2;
        i_om = 0; i_lc = 0; i_la = 0; i_st = 0;
    endtask

    initial begin
        @(posedge clk); #2;
        chk("rst_cur", 32'(cur0), 32'h0000);
        chk("rst_alm", 32'(alm1), 32'h0000);
        chk("rst_alarm", 32'(if0.alarm), 32'h0);
        reset = 0;
        en = 1;

        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 16'h0, 0);
        chk("ten_ticks", 32'(cur0), 32'h0010);
        chk("ten_alarm", 32'(if0.alarm), 32'h0);

        cyc(0, 1, 0, 16'h2359, 0); cyc(1, 0, 0, 16'h0, 0);
        chk("wrap_day", 32'(cur0), 32'h0000);
        cyc(0, 1, 0, 16'h0959, 0); cyc(1, 0, 0, 16'h0, 0);
        chk("wrap_0959", 32'(cur0), 32'h1000);
        cyc(0, 1, 0, 16'h1959, 0); cyc(1, 0, 0, 16'h0, 0);
        chk("wrap_1959", 32'(cur1), 32'h2000);

        i_om = 1; i_lc = 1; i_d = 16'h1234; #1;
        chk("rc_high", 32'(if0.reset_count), 32'h1);
        @(posedge clk); #2; i_om = 0; i_lc = 0;
        chk("load_wins", 32'(cur0), 32'h1234);
        cyc(1, 1, 0, 16'h2500, 0);
        chk("bad_load_tick", 32'(cur0), 32'h1235);

        i_btn = 1;
        cyc(0, 0, 1, 16'h0700, 0);
        cyc(0, 1, 0, 16'h0659, 0);
        cyc(1, 0, 0, 16'h0, 0);
        chk("match_time", 32'(cur0), 32'h0700);
        chk("match_edgeN", 32'(if0.alarm), 32'h0);
        cyc(0, 0, 0, 16'h0, 0);
        chk("match_edgeN1", 32'(if0.alarm), 32'h1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 16'h0, 0);
        chk("alarm_holds", 32'(if0.alarm), 32'h1);
        cyc(0, 0, 0, 16'h0, 1);
        chk("stop_clears", 32'(if0.alarm), 32'h0);

        i_btn = 0;
        cyc(0, 1, 0, 16'h0659, 0); cyc(1, 0, 0, 16'h0, 0); cyc(0, 0, 0, 16'h0, 0);
        chk("btn_off", 32'(if0.alarm), 32'h0);
        i_btn = 1;
        cyc(0, 1, 0, 16'h0659, 0); cyc(1, 0, 0, 16'h0, 0); cyc(0, 0, 0, 16'h0, 1);
        chk("stop_at_match", 32'(if0.alarm), 32'h0);
        cyc(0, 0, 0, 16'h0, 0);
        chk("no_retrigger", 32'(if0.alarm), 32'h0);

        cyc(0, 1, 0, 16'h0700, 0); cyc(0, 0, 0, 16'h0, 0);
        chk("load_eq_aol0", 32'(if0.alarm), 32'h0);
        chk("load_eq_aol1", 32'(if1.alarm), 32'h1);
        reset = 1; #1;
        chk("async_alarm", 32'(if1.alarm), 32'h0);
        chk("async_cur", 32'(cur1), 32'h0000);
        @(posedge clk); #2;
        reset = 0;

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d;
            if ($urandom_range(0, 3) == 0) d = 16'($urandom);
            else if ($urandom_range(0, 1) == 0) d = tod2bcd(int'($urandom_range(0, 1439)));
            else d = tod2bcd(m_cur[0] + int'($urandom_range(0, 3)));
            i_btn = ($urandom_range(0, 7) != 0);
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 5) == 0), d, ($urandom_range(0, 15) == 0));
        end

        en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
